// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: multicycle control FSM for the MIPS-subset datapath
module unidade_controle_multiciclo #(
  parameter int MEM_LAT    = 1,
  parameter int MD_TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       md_done,
  input  logic       md_div0,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_wr,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] data_src,
  output logic       md_start,
  output logic       md_is_div,
  output logic       hilo_write,
  output logic       epc_write,
  output logic [1:0] cause,
  output logic [4:0] estado
);
  localparam logic [4:0] S_RESET    = 5'd0,  S_FETCH   = 5'd1,  S_FWAIT    = 5'd2,  S_DECODE  = 5'd3;
  localparam logic [4:0] S_EXEC_R   = 5'd4,  S_WB_R    = 5'd5,  S_EXEC_I   = 5'd6,  S_WB_I    = 5'd7;
  localparam logic [4:0] S_MEM_ADDR = 5'd8,  S_MEM_RD  = 5'd9,  S_WB_LW    = 5'd10, S_MEM_WR  = 5'd11;
  localparam logic [4:0] S_BRANCH   = 5'd12, S_JUMP    = 5'd13, S_WB_LUI   = 5'd14, S_MD_START = 5'd15;
  localparam logic [4:0] S_MD_WAIT  = 5'd16, S_HILO    = 5'd17, S_WB_HILO  = 5'd18, S_EXC_OVF = 5'd19;
  localparam logic [4:0] S_EXC_OPC  = 5'd20, S_EXC_DZ  = 5'd21, S_EXC_TO   = 5'd22;
  logic [4:0] state, nxt, dec;
  logic [7:0] cnt;
  logic [5:0] fn_q;
  logic       unused_zero;
  assign unused_zero = zero;
  assign estado = state;
  // instruction decode: target state leaving DECODE
  always_comb begin
    dec = opcode == 6'h00 ? ((funct == 6'h20 || funct == 6'h22 || funct == 6'h24) ? S_EXEC_R :
                             (funct == 6'h18 || funct == 6'h1A) ? S_MD_START :
                             (funct == 6'h10 || funct == 6'h12) ? S_WB_HILO : S_EXC_OPC) :
          opcode == 6'h08 ? S_EXEC_I :
          (opcode == 6'h23 || opcode == 6'h2B) ? S_MEM_ADDR :
          opcode == 6'h04 ? S_BRANCH :
          opcode == 6'h02 ? S_JUMP :
          opcode == 6'h0F ? S_WB_LUI : S_EXC_OPC;
  end
  // next-state sequencing
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_RESET:    nxt = S_FETCH;
      S_FETCH:    nxt = S_FWAIT;
      S_FWAIT:    nxt = cnt == 8'd0 ? S_DECODE : S_FWAIT;
      S_DECODE:   nxt = dec;
      S_EXEC_R:   nxt = (overflow && fn_q != 6'h24) ? S_EXC_OVF : S_WB_R;
      S_EXEC_I:   nxt = overflow ? S_EXC_OVF : S_WB_I;
      S_MEM_ADDR: nxt = opcode == 6'h23 ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nxt = cnt == 8'd0 ? S_WB_LW : S_MEM_RD;
      S_MD_START: nxt = (fn_q == 6'h1A && md_div0) ? S_EXC_DZ : S_MD_WAIT;
      S_MD_WAIT:  nxt = md_done ? S_HILO : cnt == 8'(MD_TIMEOUT - 1) ? S_EXC_TO : S_MD_WAIT;
      S_WB_R, S_WB_I, S_WB_LW, S_MEM_WR, S_BRANCH, S_JUMP, S_WB_LUI, S_HILO, S_WB_HILO,
      S_EXC_OVF, S_EXC_OPC, S_EXC_DZ, S_EXC_TO: nxt = S_FETCH;
      default:    nxt = S_RESET;
    endcase
  end
  // state, shared wait/timeout counter, latched funct and sticky exception cause
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RESET;
      cnt   <= '0;
      fn_q  <= '0;
      cause <= '0;
    end else begin
      state <= nxt;
      cnt   <= (state == S_FETCH || state == S_MEM_ADDR) ? 8'(MEM_LAT) :
               (state == S_FWAIT || state == S_MEM_RD) ? cnt - 8'd1 :
               state == S_MD_WAIT ? cnt + 8'd1 : 8'd0;
      fn_q  <= state == S_DECODE ? funct : fn_q;
      cause <= nxt == S_EXC_OVF ? 2'd0 : nxt == S_EXC_OPC ? 2'd1 :
               nxt == S_EXC_DZ ? 2'd2 : nxt == S_EXC_TO ? 2'd3 : cause;
    end
  end
  // Moore output decode
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_wr        = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 3'd0;
    pc_source     = 2'd0;
    data_src      = 4'd0;
    md_start      = 1'b0;
    md_is_div     = 1'b0;
    hilo_write    = 1'b0;
    epc_write     = 1'b0;
    case (state)
      S_FWAIT: begin
        ir_write  = cnt == 8'd0;
        pc_write  = cnt == 8'd0;
        alu_src_b = cnt == 8'd0 ? 2'd1 : 2'd0;
      end
      S_DECODE: alu_src_b = 2'd3;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = fn_q == 6'h22 ? 3'd1 : fn_q == 6'h24 ? 3'd2 : 3'd0;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 2'd1;
      end
      S_WB_I: reg_write = 1'b1;
      S_MEM_RD: i_or_d = 1'b1;
      S_WB_LW: begin
        reg_write = 1'b1;
        data_src  = 4'd1;
      end
      S_MEM_WR: begin
        i_or_d = 1'b1;
        mem_wr = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'd1;
        pc_source     = 2'd1;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        pc_source = 2'd2;
        pc_write  = 1'b1;
      end
      S_WB_LUI: begin
        reg_write = 1'b1;
        data_src  = 4'd5;
      end
      S_MD_START: begin
        md_start  = 1'b1;
        md_is_div = fn_q == 6'h1A;
      end
      S_MD_WAIT: md_is_div = fn_q == 6'h1A;
      S_HILO: hilo_write = 1'b1;
      S_WB_HILO: begin
        reg_write = 1'b1;
        reg_dst   = 2'd1;
        data_src  = fn_q == 6'h10 ? 4'd2 : 4'd3;
      end
      S_EXC_OVF, S_EXC_OPC, S_EXC_DZ, S_EXC_TO: begin
        epc_write = 1'b1;
        pc_source = 2'd3;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// tb_unidade_controle_multiciclo: instruction-level schedule model checked cycle by cycle
module tb_unidade_controle_multiciclo;
  localparam int TO = 40;
  typedef struct packed {
    logic pc_write, pc_write_cond, i_or_d, mem_wr, ir_write, reg_write;
    logic [1:0] reg_dst;
    logic alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] data_src;
    logic md_start, md_is_div, hilo_write, epc_write;
    logic [1:0] cause;
  } outv_t;
  logic clk = 1'b0;
  logic rstn [2];
  logic [5:0] opcode, funct;
  logic zero, overflow, md_done, md_div0;
  logic pc_write [2], pc_write_cond [2], i_or_d [2], mem_wr [2], ir_write [2], reg_write [2];
  logic [1:0] reg_dst [2];
  logic alu_src_a [2];
  logic [1:0] alu_src_b [2];
  logic [2:0] alu_op [2];
  logic [1:0] pc_source [2];
  logic [3:0] data_src [2];
  logic md_start [2], md_is_div [2], hilo_write [2], epc_write [2];
  logic [1:0] cause [2];
  logic [4:0] estado [2];
  outv_t pk [2];
  outv_t q [$];
  logic [1:0] exp_cause;
  int sel, total, bad, last_n, cyc;
  int cnt_rw, cnt_mw, cnt_io, cnt_ms, cnt_hw, cnt_ep;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gd
    unidade_controle_multiciclo #(.MEM_LAT(g ? 3 : 1), .MD_TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(rstn[g]), .opcode(opcode), .funct(funct), .zero(zero),
      .overflow(overflow), .md_done(md_done), .md_div0(md_div0),
      .pc_write(pc_write[g]), .pc_write_cond(pc_write_cond[g]), .i_or_d(i_or_d[g]),
      .mem_wr(mem_wr[g]), .ir_write(ir_write[g]), .reg_write(reg_write[g]), .reg_dst(reg_dst[g]),
      .alu_src_a(alu_src_a[g]), .alu_src_b(alu_src_b[g]), .alu_op(alu_op[g]),
      .pc_source(pc_source[g]), .data_src(data_src[g]), .md_start(md_start[g]),
      .md_is_div(md_is_div[g]), .hilo_write(hilo_write[g]), .epc_write(epc_write[g]),
      .cause(cause[g]), .estado(estado[g]));
    assign pk[g] = {pc_write[g], pc_write_cond[g], i_or_d[g], mem_wr[g], ir_write[g], reg_write[g],
                    reg_dst[g], alu_src_a[g], alu_src_b[g], alu_op[g], pc_source[g], data_src[g],
                    md_start[g], md_is_div[g], hilo_write[g], epc_write[g], cause[g]};
  end
  function automatic outv_t blank();
    outv_t e;
    e = '0;
    e.cause = exp_cause;
    return e;
  endfunction
  task automatic exc(input logic [1:0] c);
    outv_t e;
    exp_cause = c;
    e = blank();
    e.epc_write = 1'b1;
    e.pc_source = 2'd3;
    e.pc_write = 1'b1;
    q.push_back(e);
  endtask
  task automatic wb(input logic [1:0] dst, input logic [3:0] ds);
    outv_t e;
    e = blank();
    e.reg_write = 1'b1;
    e.reg_dst = dst;
    e.data_src = ds;
    q.push_back(e);
  endtask
  // expected per-cycle outputs of one whole instruction, from fetch to its last state
  task automatic plan(input logic [5:0] op, fn, input logic ovf, div0, input int md_k, lat,
                      output int n, output int mdi);
    outv_t e;
    int s;
    s = q.size();
    mdi = md_k;
    q.push_back(blank());
    for (int i = 0; i < lat; i++) q.push_back(blank());
    e = blank(); e.ir_write = 1'b1; e.alu_src_b = 2'd1; e.pc_write = 1'b1; q.push_back(e);
    e = blank(); e.alu_src_b = 2'd3; q.push_back(e);
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      e = blank(); e.alu_src_a = 1'b1;
      e.alu_op = fn == 6'h22 ? 3'd1 : fn == 6'h24 ? 3'd2 : 3'd0;
      q.push_back(e);
      if (ovf && fn != 6'h24) exc(2'd0); else wb(2'd1, 4'd0);
    end else if (op == 6'h08) begin
      e = blank(); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; q.push_back(e);
      if (ovf) exc(2'd0); else wb(2'd0, 4'd0);
    end else if (op == 6'h23 || op == 6'h2B) begin
      e = blank(); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; q.push_back(e);
      e = blank(); e.i_or_d = 1'b1;
      if (op == 6'h23) begin
        for (int i = 0; i <= lat; i++) q.push_back(e);
        wb(2'd0, 4'd1);
      end else begin
        e.mem_wr = 1'b1;
        q.push_back(e);
      end
    end else if (op == 6'h04) begin
      e = blank(); e.alu_src_a = 1'b1; e.alu_op = 3'd1; e.pc_source = 2'd1; e.pc_write_cond = 1'b1;
      q.push_back(e);
    end else if (op == 6'h02) begin
      e = blank(); e.pc_source = 2'd2; e.pc_write = 1'b1; q.push_back(e);
    end else if (op == 6'h0F) begin
      wb(2'd0, 4'd5);
    end else if (op == 6'h00 && (fn == 6'h18 || fn == 6'h1A)) begin
      e = blank(); e.md_start = 1'b1; e.md_is_div = fn == 6'h1A; q.push_back(e);
      if (fn == 6'h1A && div0) exc(2'd2);
      else begin
        e = blank(); e.md_is_div = fn == 6'h1A;
        if (md_k >= 0 && md_k < TO) begin
          mdi = q.size() - s + md_k;
          for (int i = 0; i <= md_k; i++) q.push_back(e);
          e = blank(); e.hilo_write = 1'b1; q.push_back(e);
        end else begin
          mdi = -1;
          for (int i = 0; i < TO; i++) q.push_back(e);
          exc(2'd3);
        end
      end
    end else if (op == 6'h00 && (fn == 6'h10 || fn == 6'h12)) begin
      wb(2'd1, fn == 6'h10 ? 4'd2 : 4'd3);
    end else exc(2'd1);
    n = q.size() - s;
  endtask
  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask
  // drive one instruction starting in FETCH; md_done pulses in schedule cycle mdi
  task automatic run(input logic [5:0] op, fn, input logic ovf, div0, zr, input int md_k, cut);
    int n, mdi, lim;
    opcode = op; funct = fn; overflow = ovf; md_div0 = div0; zero = zr; md_done = 1'b0;
    cnt_rw = 0; cnt_mw = 0; cnt_io = 0; cnt_ms = 0; cnt_hw = 0; cnt_ep = 0;
    plan(op, fn, ovf, div0, md_k, sel ? 3 : 1, n, mdi);
    last_n = n;
    lim = cut > 0 ? cut : n;
    for (int i = 0; i < lim; i++) begin
      md_done = i == mdi;
      @(posedge clk); #1;
    end
    md_done = 1'b0;
  endtask
  // single compare process: active DUT against the model schedule
  always @(negedge clk) begin
    outv_t a, e;
    a = pk[sel];
    cyc++;
    cnt_rw += int'(a.reg_write); cnt_mw += int'(a.mem_wr); cnt_io += int'(a.i_or_d);
    cnt_ms += int'(a.md_start); cnt_hw += int'(a.hilo_write); cnt_ep += int'(a.epc_write);
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL sched cyc=%0d dut%0d got=%h want=%h", cyc, sel, a, e);
      end
    end
  end
  initial begin
    rstn[0] = 1'b0; rstn[1] = 1'b0;
    opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0; md_done = 1'b0; md_div0 = 1'b0;
    sel = 0; exp_cause = '0; total = 0; bad = 0; cyc = 0;
    repeat (2) @(negedge clk);
    chk("reset_out0", int'(pk[0]), 0);
    chk("reset_out1", int'(pk[1]), 0);
    @(posedge clk); #1 rstn[0] = 1'b1;
    @(posedge clk); #1;
    run(6'h00, 6'h20, 1'b0, 1'b0, 1'b0, -1, 0);
    chk("add_len", last_n, 6);
    chk("add_rw", cnt_rw, 1);
    run(6'h00, 6'h22, 1'b1, 1'b0, 1'b0, -1, 0);
    chk("sub_ovf_rw", cnt_rw, 0);
    run(6'h00, 6'h24, 1'b1, 1'b0, 1'b0, -1, 0);
    chk("and_ovf_rw", cnt_rw, 1);
    run(6'h08, 6'h00, 1'b1, 1'b0, 1'b0, -1, 0);
    chk("addi_ovf_rw", cnt_rw, 0);
    chk("addi_ovf_epc", cnt_ep, 1);
    chk("addi_ovf_cause", int'(cause[0]), 0);
    run(6'h08, 6'h00, 1'b0, 1'b0, 1'b0, -1, 0);
    run(6'h04, 6'h00, 1'b0, 1'b0, 1'b1, -1, 0);
    run(6'h02, 6'h00, 1'b0, 1'b0, 1'b0, 2, 0);
    run(6'h0F, 6'h00, 1'b0, 1'b0, 1'b0, -1, 0);
    run(6'h00, 6'h1A, 1'b0, 1'b0, 1'b0, 32, 0);
    chk("div_mdstart", cnt_ms, 1);
    chk("div_hilo", cnt_hw, 1);
    chk("div_rw", cnt_rw, 0);
    run(6'h00, 6'h12, 1'b0, 1'b0, 1'b0, -1, 0);
    run(6'h00, 6'h10, 1'b0, 1'b0, 1'b0, -1, 0);
    run(6'h00, 6'h18, 1'b0, 1'b0, 1'b0, -1, 0);
    chk("to_len", last_n, 46);
    chk("to_cause", int'(cause[0]), 3);
    chk("to_hilo", cnt_hw, 0);
    run(6'h3F, 6'h00, 1'b0, 1'b0, 1'b0, -1, 0);
    chk("opc_cause", int'(cause[0]), 1);
    run(6'h00, 6'h20, 1'b0, 1'b0, 1'b0, -1, 0);
    run(6'h00, 6'h3F, 1'b0, 1'b0, 1'b0, -1, 0);
    chk("fn_cause", int'(cause[0]), 1);
    run(6'h00, 6'h1A, 1'b0, 1'b1, 1'b0, -1, 0);
    chk("dz_cause", int'(cause[0]), 2);
    chk("dz_hilo", cnt_hw, 0);
    run(6'h00, 6'h18, 1'b0, 1'b0, 1'b0, TO - 1, 0);
    chk("edge_done_hilo", cnt_hw, 1);
    chk("edge_done_cause", int'(cause[0]), 2);
    run(6'h00, 6'h18, 1'b0, 1'b0, 1'b0, -1, 10);
    #2;
    q.delete();
    rstn[0] = 1'b0;
    exp_cause = '0;
    #1;
    chk("async_rst_out", int'(pk[0]), 0);
    @(posedge clk); #1 rstn[0] = 1'b1;
    @(posedge clk); #1;
    run(6'h00, 6'h20, 1'b0, 1'b0, 1'b0, -1, 0);
    chk("post_rst_len", last_n, 6);
    rstn[0] = 1'b0;
    sel = 1;
    exp_cause = '0;
    rstn[1] = 1'b1;
    @(posedge clk); #1;
    run(6'h23, 6'h00, 1'b0, 1'b0, 1'b0, -1, 0);
    chk("lw_len", last_n, 12);
    chk("lw_memrd", cnt_io, 4);
    chk("lw_rw", cnt_rw, 1);
    run(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, -1, 0);
    chk("sw_memwr", cnt_mw, 1);
    chk("sw_rw", cnt_rw, 0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
